dir_encoder: RTL and testbench

//   Transmit-side counterpart of the direction channel. Accepts a 3-bit direction code
//   on a valid/ready handshake and serialises it into a framed stream of signed 8-bit samples.

---
 rtl/dir_pkg.sv | 34 +++
 rtl/sample_strobe_gen.sv | 44 ++++
 rtl/dir_encoder.sv | 185 ++++++++++++++++++
 tb/tb_dir_encoder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
// -----------------------------------------------------------------------------
// dir_pkg
//   Shared definitions for the direction channel blocks: direction code width,
//   encoder state type, Manchester constants and small elaboration helpers.
//   Imported by dir_encoder and anything else that talks direction codes.
// -----------------------------------------------------------------------------
package dir_pkg;

  localparam int DIR_W        = 3;
  localparam int MANCH_HALVES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_SYM,
    ST_GAP
  } enc_state_t;

  // Manchester line level for one half of a bit: a 1 is sent high-then-low,
  // a 0 low-then-high, so the level is just the bit flipped on the second half.
  function automatic logic manch_high(input logic bit_val, input logic second_half);
    return bit_val ^ second_half;
  endfunction

  // Largest of three non-negative counts, used to size a shared sample counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sample_strobe_gen.sv
// -----------------------------------------------------------------------------
// sample_strobe_gen
//   Free-running clock divider that marks every CLK_DIV-th cycle. A synchronous
//   clear restarts the count so a consumer can align its sample grid to an
//   event (e.g. a handshake); the tick then fires CLK_DIV cycles after the clear.
//
// Ports
//   i_clk   in   rising-edge clock
//   i_rst   in   asynchronous active-low reset
//   i_clr   in   synchronous restart of the divider
//   o_tick  out  high during the last cycle of each CLK_DIV period
// -----------------------------------------------------------------------------
module sample_strobe_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // The divider counts 0..CLK_DIV-1 and wraps. A clear forces it back to zero
  // so the next tick lands exactly CLK_DIV cycles later. With CLK_DIV=1 the
  // count is pinned at zero and the tick is permanently high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      div_cnt <= '0;
    end else if (i_clr || (div_cnt == DIV_LAST)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // The tick is decoded straight from the count so the consumer can register
  // its sample on the edge that closes the period.
  assign o_tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/dir_encoder.sv
// -----------------------------------------------------------------------------
// dir_encoder
//   Transmit side of the direction channel. Takes a 3-bit direction code on a
//   valid/ready handshake and plays it out as a framed stream of signed 8-bit
//   samples: PRE_LEN x -AMP preamble, three Manchester bits MSB first (SPS
//   samples per half-bit), then GAP_LEN zero samples. Each sample is marked by
//   a one-cycle o_enb strobe; strobes are CLK_DIV cycles apart.
//
// Ports
//   i_clk    in   rising-edge clock
//   i_rst    in   asynchronous active-low reset
//   i_dir    in   direction code, captured on accept
//   i_valid  in   i_dir is valid
//   o_ready  out  encoder idle and able to accept a code (registered)
//   o_data   out  signed sample, held between strobes, 0 when idle
//   o_enb    out  one-cycle strobe, o_data is a new sample
//   o_busy   out  frame in progress
// -----------------------------------------------------------------------------
module dir_encoder
  import dir_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int PRE_LEN = 4,
  parameter int SPS     = 2,
  parameter int AMP     = 64,
  parameter int GAP_LEN = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [DIR_W-1:0]        i_dir,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [7:0]       o_data,
  output logic                    o_enb,
  output logic                    o_busy
);

  // One counter is shared by the preamble, each half-bit and the gap, so it is
  // sized for the longest of the three.
  localparam int CNT_MAX = max3(PRE_LEN, SPS, GAP_LEN);
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int BIT_W   = (DIR_W > 1) ? $clog2(DIR_W) : 1;

  localparam logic signed [7:0] POS_AMP  = 8'(AMP);
  localparam logic signed [7:0] NEG_AMP  = 8'(-AMP);

  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_LEN);
  localparam logic [CNT_W-1:0]  SPS_LAST = CNT_W'(SPS);
  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_LEN);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0]  BIT_MSB  = BIT_W'(DIR_W - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE  = BIT_W'(1);
  localparam logic              HALF_LAST = 1'(MANCH_HALVES - 1);

  enc_state_t        state;
  logic [DIR_W-1:0]  dir_q;
  logic [CNT_W-1:0]  samp_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              half;
  logic              accept;
  logic              tick;
  logic              sym_last;

  function automatic logic signed [7:0] level(input logic high);
    return high ? POS_AMP : NEG_AMP;
  endfunction

  // A transfer happens whenever the source offers a code while we are idle.
  // o_ready is registered, so this is a pure AND of two flop-level signals.
  assign accept = i_valid & o_ready;

  // The last Manchester sample has been sent once we are on the final half of
  // bit 0 and that half has all of its SPS samples out.
  assign sym_last = (bit_idx == '0) && (half == HALF_LAST) && (samp_cnt == SPS_LAST);

  // The divider is restarted on accept so the sample grid is anchored to the
  // handshake: the first sample goes out on the accept edge itself and every
  // later one on a tick, CLK_DIV cycles apart.
  sample_strobe_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_strobe (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (accept),
    .o_tick (tick)
  );

  // Frame sequencer. samp_cnt counts samples already emitted in the current
  // section (preamble, half-bit or gap). Each tick emits the next sample and
  // advances the position; leaving the final section does not wait for a
  // tick, so the encoder is idle again in the cycle after the last strobe and
  // a waiting source can start the next frame immediately.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= ST_IDLE;
      dir_q    <= '0;
      samp_cnt <= '0;
      bit_idx  <= '0;
      half     <= 1'b0;
      o_data   <= '0;
      o_enb    <= 1'b0;
      o_busy   <= 1'b0;
      o_ready  <= 1'b1;
    end else begin
      o_enb <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          o_data <= '0;
          if (accept) begin
            dir_q    <= i_dir;
            state    <= ST_PRE;
            samp_cnt <= CNT_ONE;
            o_data   <= NEG_AMP;
            o_enb    <= 1'b1;
            o_busy   <= 1'b1;
            o_ready  <= 1'b0;
          end
        end

        ST_PRE: begin
          if (tick) begin
            o_enb <= 1'b1;
            if (samp_cnt == PRE_LAST) begin
              state    <= ST_SYM;
              bit_idx  <= BIT_MSB;
              half     <= 1'b0;
              samp_cnt <= CNT_ONE;
              o_data   <= level(manch_high(dir_q[BIT_MSB], 1'b0));
            end else begin
              samp_cnt <= samp_cnt + CNT_ONE;
              o_data   <= NEG_AMP;
            end
          end
        end

        ST_SYM: begin
          if (sym_last) begin
            if (GAP_LEN == 0) begin
              state    <= ST_IDLE;
              samp_cnt <= '0;
              o_data   <= '0;
              o_busy   <= 1'b0;
              o_ready  <= 1'b1;
            end else if (tick) begin
              state    <= ST_GAP;
              samp_cnt <= CNT_ONE;
              o_data   <= '0;
              o_enb    <= 1'b1;
            end
          end else if (tick) begin
            o_enb <= 1'b1;
            if (samp_cnt != SPS_LAST) begin
              samp_cnt <= samp_cnt + CNT_ONE;
              o_data   <= level(manch_high(dir_q[bit_idx], half));
            end else if (half != HALF_LAST) begin
              half     <= HALF_LAST;
              samp_cnt <= CNT_ONE;
              o_data   <= level(manch_high(dir_q[bit_idx], HALF_LAST));
            end else begin
              bit_idx  <= bit_idx - BIT_ONE;
              half     <= 1'b0;
              samp_cnt <= CNT_ONE;
              o_data   <= level(manch_high(dir_q[bit_idx - BIT_ONE], 1'b0));
            end
          end
        end

        ST_GAP: begin
          if (samp_cnt == GAP_LAST) begin
            state    <= ST_IDLE;
            samp_cnt <= '0;
            o_data   <= '0;
            o_busy   <= 1'b0;
            o_ready  <= 1'b1;
          end else if (tick) begin
            samp_cnt <= samp_cnt + CNT_ONE;
            o_data   <= '0;
            o_enb    <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dir_encoder.sv
// -----------------------------------------------------------------------------
// tb_dir_encoder
//   Three dir_encoder instances with different parameter sets driven by
//   directed and $urandom frames. Expected samples come from a frame model
//   built from the channel rules (preamble, Manchester halves, gap) using
//   plain index arithmetic; strobe spacing and idle return are timed in
//   cycles from the accept edge.
// -----------------------------------------------------------------------------
module tb_dir_encoder;

  localparam int A_CD = 4, A_PRE = 4, A_SPS = 2, A_AMP = 64,  A_GAP = 2;
  localparam int B_CD = 1, B_PRE = 4, B_SPS = 2, B_AMP = 64,  B_GAP = 2;
  localparam int C_CD = 3, C_PRE = 1, C_SPS = 1, C_AMP = 100, C_GAP = 0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        dir_in   [3];
  logic              valid_in [3];
  logic              ready_out[3];
  logic signed [7:0] data_out [3];
  logic              enb_out  [3];
  logic              busy_out [3];

  int checks = 0;
  int errors = 0;
  int obsData[64];
  int obsTime[64];

  always #5 clk = ~clk;

  dir_encoder #(.CLK_DIV(A_CD), .PRE_LEN(A_PRE), .SPS(A_SPS), .AMP(A_AMP), .GAP_LEN(A_GAP)) u_a (
    .i_clk(clk), .i_rst(rst_n), .i_dir(dir_in[0]), .i_valid(valid_in[0]),
    .o_ready(ready_out[0]), .o_data(data_out[0]), .o_enb(enb_out[0]), .o_busy(busy_out[0]));

  dir_encoder #(.CLK_DIV(B_CD), .PRE_LEN(B_PRE), .SPS(B_SPS), .AMP(B_AMP), .GAP_LEN(B_GAP)) u_b (
    .i_clk(clk), .i_rst(rst_n), .i_dir(dir_in[1]), .i_valid(valid_in[1]),
    .o_ready(ready_out[1]), .o_data(data_out[1]), .o_enb(enb_out[1]), .o_busy(busy_out[1]));

  dir_encoder #(.CLK_DIV(C_CD), .PRE_LEN(C_PRE), .SPS(C_SPS), .AMP(C_AMP), .GAP_LEN(C_GAP)) u_c (
    .i_clk(clk), .i_rst(rst_n), .i_dir(dir_in[2]), .i_valid(valid_in[2]),
    .o_ready(ready_out[2]), .o_data(data_out[2]), .o_enb(enb_out[2]), .o_busy(busy_out[2]));

  function automatic int pCd(input int k);
    return (k == 0) ? A_CD : (k == 1) ? B_CD : C_CD;
  endfunction
  function automatic int pPre(input int k);
    return (k == 0) ? A_PRE : (k == 1) ? B_PRE : C_PRE;
  endfunction
  function automatic int pSps(input int k);
    return (k == 0) ? A_SPS : (k == 1) ? B_SPS : C_SPS;
  endfunction
  function automatic int pAmp(input int k);
    return (k == 0) ? A_AMP : (k == 1) ? B_AMP : C_AMP;
  endfunction
  function automatic int pGap(input int k);
    return (k == 0) ? A_GAP : (k == 1) ? B_GAP : C_GAP;
  endfunction

  function automatic int frameLen(input int k);
    return pPre(k) + 6 * pSps(k) + pGap(k);
  endfunction

  // Reference frame: sample number idx of the frame carrying code d.
  function automatic int expSample(input int k, input logic [2:0] d, input int idx);
    int pos;
    int bitNo;
    int b;
    int firstHalf;
    if (idx < pPre(k)) return -pAmp(k);
    pos = idx - pPre(k);
    if (pos < 6 * pSps(k)) begin
      bitNo     = pos / (2 * pSps(k));
      b         = int'(d[2 - bitNo]);
      firstHalf = ((pos % (2 * pSps(k))) < pSps(k)) ? 1 : 0;
      return (b == firstHalf) ? pAmp(k) : -pAmp(k);
    end
    return 0;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Called right after the accept edge. Collects strobes cycle by cycle
  // (sampled on the falling edge) until the encoder reports idle, then
  // compares the frame against the reference model.
  task automatic captureFrame(input int k, input logic [2:0] d, input int pokeC,
                              input logic [2:0] pokeD, input bit keepValid);
    int n;
    int idleC;
    int idleData;
    int idleEnb;
    int len;
    int budget;
    len      = frameLen(k);
    budget   = len * pCd(k) + 10;
    n        = 0;
    idleC    = -1;
    idleData = 0;
    idleEnb  = 0;
    #1;
    if (!keepValid) valid_in[k] = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (c == pokeC) dir_in[k] = pokeD;
      if (c == 0) begin
        checkOutput($sformatf("i%0d_busy_after_accept", k), int'(busy_out[k]), 1);
        checkOutput($sformatf("i%0d_ready_after_accept", k), int'(ready_out[k]), 0);
      end
      if (enb_out[k]) begin
        if (n < 64) begin
          obsData[n] = int'(data_out[k]);
          obsTime[n] = c;
        end
        n++;
      end
      if (ready_out[k] && !busy_out[k]) begin
        idleC    = c;
        idleData = int'(data_out[k]);
        idleEnb  = int'(enb_out[k]);
        break;
      end
    end
    checkOutput($sformatf("i%0d_strobe_count", k), n, len);
    for (int i = 0; i < len && i < n && i < 64; i++) begin
      checkOutput($sformatf("i%0d_sample%0d", k, i), obsData[i], expSample(k, d, i));
      checkOutput($sformatf("i%0d_time%0d", k, i), obsTime[i], i * pCd(k));
    end
    checkOutput($sformatf("i%0d_idle_cycle", k), idleC, (len - 1) * pCd(k) + 1);
    checkOutput($sformatf("i%0d_idle_data", k), idleData, 0);
    checkOutput($sformatf("i%0d_idle_enb", k), idleEnb, 0);
  endtask

  task automatic applyStimulus(input int k, input logic [2:0] d, input int pokeC,
                               input logic [2:0] pokeD, input bit keepValid);
    @(negedge clk);
    dir_in[k]   = d;
    valid_in[k] = 1'b1;
    @(posedge clk);
    captureFrame(k, d, pokeC, pokeD, keepValid);
  endtask

  initial begin
    int         n;
    int         cnt;
    int         k;
    logic [2:0] d;
    logic [2:0] d2;

    for (int i = 0; i < 3; i++) begin
      dir_in[i]   = 3'd0;
      valid_in[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("i%0d_rst_ready", i), int'(ready_out[i]), 1);
      checkOutput($sformatf("i%0d_rst_busy", i), int'(busy_out[i]), 0);
      checkOutput($sformatf("i%0d_rst_enb", i), int'(enb_out[i]), 0);
      checkOutput($sformatf("i%0d_rst_data", i), int'(data_out[i]), 0);
    end

    // valid already high as reset releases: accepted on the first edge
    d           = 3'($urandom_range(0, 7));
    dir_in[1]   = d;
    valid_in[1] = 1'b1;
    rst_n       = 1'b1;
    @(posedge clk);
    captureFrame(1, d, -1, 3'd0, 1'b0);

    $display("[TB] default frame, code 101");
    applyStimulus(0, 3'b101, -1, 3'd0, 1'b0);

    $display("[TB] CLK_DIV=1, code 000");
    applyStimulus(1, 3'b000, -1, 3'd0, 1'b0);

    $display("[TB] short frame, no gap");
    applyStimulus(2, 3'($urandom_range(0, 7)), -1, 3'd0, 1'b0);

    $display("[TB] code changed one cycle after accept");
    applyStimulus(0, 3'b011, 0, 3'b100, 1'b0);

    $display("[TB] valid held with new code mid-frame, back-to-back");
    d  = 3'($urandom_range(0, 7));
    d2 = ~d;
    applyStimulus(0, d, 10, d2, 1'b1);
    @(posedge clk);
    captureFrame(0, d2, -1, 3'd0, 1'b0);

    $display("[TB] random frames");
    for (int it = 0; it < 6; it++) begin
      k = int'($urandom_range(0, 2));
      applyStimulus(k, 3'($urandom_range(0, 7)), -1, 3'd0, 1'b0);
    end

    $display("[TB] reset at strobe 9");
    @(negedge clk);
    dir_in[0]   = 3'b110;
    valid_in[0] = 1'b1;
    @(posedge clk);
    #1 valid_in[0] = 1'b0;
    n = 0;
    for (int c = 0; c < 200 && n < 9; c++) begin
      @(negedge clk);
      if (enb_out[0]) n++;
    end
    checkOutput("rst_reach_strobe9", n, 9);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midrst_data", int'(data_out[0]), 0);
    checkOutput("midrst_enb", int'(enb_out[0]), 0);
    checkOutput("midrst_busy", int'(busy_out[0]), 0);
    checkOutput("midrst_ready", int'(ready_out[0]), 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (enb_out[0] || busy_out[0]) cnt++;
    end
    checkOutput("no_activity_after_rst", cnt, 0);
    checkOutput("ready_after_rst", int'(ready_out[0]), 1);

    $display("[TB] frame after reset");
    applyStimulus(0, 3'($urandom_range(0, 7)), -1, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
